// File: rtl/instr_fetch_if.sv
// ============================================================================
// instr_fetch_if : fetch-stage bus (redirect, imem request/response, decode)
// Revision       : 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_if #(
  parameter int PC_WIDTH_LENGTH = 32,
  parameter int INSTR_WIDTH     = 32
);

  logic                       redirect;
  logic [PC_WIDTH_LENGTH-1:0] redirect_pc;

  logic                       imem_req;
  logic [PC_WIDTH_LENGTH-1:0] imem_addr;
  logic                       imem_gnt;
  logic                       imem_rvalid;
  logic [INSTR_WIDTH-1:0]     imem_rdata;

  logic                       instr_valid;
  logic [INSTR_WIDTH-1:0]     instr_out;
  logic [PC_WIDTH_LENGTH-1:0] instr_pc;
  logic                       instr_ready;

  modport master (
    input  redirect,
    input  redirect_pc,
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output instr_valid,
    output instr_out,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    output redirect,
    output redirect_pc,
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  instr_valid,
    input  instr_out,
    input  instr_pc,
    output instr_ready
  );

endinterface : instr_fetch_if

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch : single-outstanding instruction fetch with {pc,instr} buffer
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter int PC_WIDTH_LENGTH = 32,
  parameter int INSTR_WIDTH     = 32,
  parameter int BUF_DEPTH       = 2
) (
  input  wire logic      clk,
  input  wire logic      reset,
  instr_fetch_if.master  bus
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e                     state_q,       state_d;
  logic [PC_WIDTH_LENGTH-1:0] fetch_addr_q,  fetch_addr_d;
  logic [PC_WIDTH_LENGTH-1:0] issued_addr_q, issued_addr_d;
  logic                       outstanding_q, outstanding_d;
  logic                       drop_q,        drop_d;
  logic [PTR_W-1:0]           wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q,      rd_ptr_d;
  logic [CNT_W-1:0]           count_q,       count_d;

  logic [PC_WIDTH_LENGTH-1:0] pc_mem    [BUF_DEPTH];
  logic [INSTR_WIDTH-1:0]     instr_mem [BUF_DEPTH];

  logic                       buf_valid;
  logic                       pop;
  logic                       rsp_hit;
  logic                       push;
  logic [CNT_W:0]             occ_after_pop;
  logic                       room;
  logic                       req;
  logic                       gnt_hs;
  logic [PC_WIDTH_LENGTH-1:0] redirect_aligned;

  assign buf_valid = (count_q != '0);

  // Redirect cycles neither consume nor accept data: the buffer is being flushed.
  assign pop     = buf_valid && bus.instr_ready && !bus.redirect;
  assign rsp_hit = bus.imem_rvalid && outstanding_q;
  assign push    = rsp_hit && !drop_q && !bus.redirect;

  assign occ_after_pop = {1'b0, count_q} - (CNT_W+1)'(pop) + (CNT_W+1)'(outstanding_q);
  assign room          = (occ_after_pop < (CNT_W+1)'(BUF_DEPTH));

  assign req    = (state_q == S_REQ) && room && !bus.redirect && !drop_q;
  assign gnt_hs = req && bus.imem_gnt;

  assign redirect_aligned = {bus.redirect_pc[PC_WIDTH_LENGTH-1:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    issued_addr_d = issued_addr_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (rsp_hit) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
    end

    if (gnt_hs) begin
      outstanding_d = 1'b1;
      issued_addr_d = fetch_addr_q;
      fetch_addr_d  = fetch_addr_q + PC_WIDTH_LENGTH'(4);
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    case (state_q)
      S_IDLE: begin
        if (room) state_d = S_REQ;
      end
      S_REQ: begin
        if (gnt_hs) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_hit) state_d = (count_d < CNT_W'(BUF_DEPTH)) ? S_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // An in-flight response that misses the redirect cycle belongs to the old stream.
    if (bus.redirect) begin
      state_d      = S_REQ;
      fetch_addr_d = redirect_aligned;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      if (outstanding_q && !bus.imem_rvalid) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      fetch_addr_q  <= '0;
      issued_addr_q <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      issued_addr_q <= issued_addr_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= issued_addr_q;
      instr_mem[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_addr_q;
  assign bus.instr_valid = buf_valid;
  assign bus.instr_out   = buf_valid ? instr_mem[rd_ptr_q] : '0;
  assign bus.instr_pc    = buf_valid ? pc_mem[rd_ptr_q]    : '0;

  a_req_stable : assert property (@(posedge clk) disable iff (!reset)
    (bus.imem_req && !bus.imem_gnt) |=> (bus.redirect || (bus.imem_req && $stable(bus.imem_addr))));

  a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (count_q == CNT_W'(BUF_DEPTH))));

endmodule : instr_fetch

`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_WIDTH_LENGTH, default 32, address width for fetch and redirect PCs.
REQ-002 Parameter INSTR_WIDTH, default 32, instruction word width.
REQ-003 Parameter BUF_DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of clk.
REQ-006 redirect  input  1  1 = restart fetch at redirect_pc (taken branch/jump from PC stage).
REQ-007 redirect_pc  input  PC_WIDTH_LENGTH  new fetch address, sampled when redirect=1.
REQ-008 imem_req  output  1  instruction memory request valid.
REQ-009 imem_addr  output  PC_WIDTH_LENGTH  request address, word aligned.
REQ-010 imem_gnt  input  1  memory accepts request this cycle (meaningful only with imem_req=1).
REQ-011 imem_rvalid  input  1  response data valid; responses in order, >=1 cycle after gnt.
REQ-012 imem_rdata  input  INSTR_WIDTH  response instruction word.
REQ-013 instr_valid  output  1  buffer head holds a valid instruction.
REQ-014 instr_out  output  INSTR_WIDTH  instruction at buffer head.
REQ-015 instr_pc  output  PC_WIDTH_LENGTH  address of instr_out.
REQ-016 instr_ready  input  1  decode consumes head when instr_valid=1 and instr_ready=1.

Function
REQ-017 The block SHALL hold fetch_addr, a BUF_DEPTH-entry FIFO of {pc, instr}, an outstanding flag and a drop flag.
REQ-018 The request FSM SHALL have states IDLE, REQ, WAIT: IDLE->REQ first cycle after reset release; REQ->WAIT on imem_gnt; WAIT->REQ on imem_rvalid if room, else WAIT->IDLE; IDLE->REQ when room returns.
REQ-019 "Room" SHALL mean FIFO count + outstanding < BUF_DEPTH, evaluated after this cycle's pop.
REQ-020 imem_req SHALL be 1 only in REQ with room and redirect=0; at most one request outstanding.
REQ-021 imem_addr SHALL equal fetch_addr and SHALL stay stable while imem_req=1 and imem_gnt=0.
REQ-022 On gnt, fetch_addr SHALL advance by 4, wrapping modulo 2^PC_WIDTH_LENGTH (0xFFFFFFFC -> 0x00000000).
REQ-023 On imem_rvalid with drop=0, {issued address, imem_rdata} SHALL be pushed; with drop=1 the response SHALL be discarded and drop cleared.
REQ-024 instr_valid SHALL be 1 whenever FIFO not empty; instr_out/instr_pc SHALL show the head combinationally.
REQ-025 Pop on instr_valid & instr_ready; simultaneous push and pop SHALL leave count unchanged; push into a full FIFO SHALL not occur by construction (REQ-019).
REQ-026 Minimum latency: redirect in cycle N -> imem_req in N+1 -> with gnt in N+1 and rvalid in N+2, instr_valid=1 in N+3.
REQ-027 On redirect=1: FIFO flushed, fetch_addr <= {redirect_pc[PC_WIDTH_LENGTH-1:2], 2'b00}, FSM -> REQ; any pop that cycle SHALL be ignored.
REQ-028 If a request is outstanding at redirect and its rvalid does not arrive the same cycle, drop SHALL be set; an rvalid in the redirect cycle SHALL be discarded.
REQ-029 While drop=1, new requests SHALL wait until the dropped response returns.
REQ-030 Redirect asserted in consecutive cycles SHALL take the latest redirect_pc.

Reset
REQ-031 While reset=0: imem_req=0, imem_addr=0, instr_valid=0, instr_out=0, instr_pc=0, fetch_addr=0, FIFO empty, outstanding=0, drop=0, FSM=IDLE.
REQ-032 Reset assertion mid-transaction SHALL abandon it; a late imem_rvalid after release SHALL be ignored (outstanding=0).
REQ-033 First request after reset release SHALL be to address 0x00000000.

Verification
REQ-034 Release reset, gnt immediate, rvalid 1 cycle later, ready=1 -> instr_pc sequence 0x0,0x4,0x8 with matching rdata, one instruction every 2 cycles.
REQ-035 instr_ready=0 for 10 cycles -> exactly 2 buffered entries, imem_req=0 once full, no loss or reorder after ready=1.
REQ-036 Redirect to 0x103 while request outstanding -> fetch resumes at 0x100, outstanding response discarded, first instr_pc=0x100.
REQ-037 Redirect to 0xFFFFFFF8 -> fetched addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-038 Hold imem_gnt=0 for 5 cycles -> imem_req and imem_addr stable throughout.
REQ-039 Assert reset=0 between clock edges during WAIT -> outputs zero immediately; after release first request address 0x0.
